ldl_reconstruct: RTL

LDL_RECONSTRUCT -- requirements
Module: ldl_reconstruct

---
 rtl/ldl_reconstruct.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ldl_reconstruct.sv
// ldl_reconstruct: rebuilds a symmetric matrix A = L * D * L^T from its LDL^T factors.
// One product term L[i][k]*D[k][k]*L[j][k] is accumulated per clock. k is the innermost loop,
// then j, then i. A full matrix takes N^3 cycles. The finished result is copied to matrix_out
// in a single update.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst        - asynchronous active-low reset
//   start      - request; sampled only while idle
//   L_in       - factor L, row-major; element (i,j) at [W*(i*N+j) +: W]
//   D_in       - factor D, same packing; only the diagonal is used
//   busy       - high while a reconstruction is running or completing
//   done       - one-cycle completion pulse
//   matrix_out - reconstructed A, same packing; held between completions
module ldl_reconstruct #(
   parameter int unsigned N = 3,
   parameter int unsigned W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W*N*N-1:0] L_in,
   input  logic [W*N*N-1:0] D_in,
   output logic             busy,
   output logic             done,
   output logic [W*N*N-1:0] matrix_out
);

   localparam int unsigned NE = N * N;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   // Headroom for N signed products of three W-bit values.
   localparam int unsigned AW = 3 * W + CW + 1;

   typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

   state_e                 state_q, state_d;
   logic [CW-1:0]          i_q, i_d, j_q, j_d, k_q, k_d;
   logic signed [AW-1:0]   acc_q, acc_d;
   logic [W*NE-1:0]        l_q, l_d, d_q, d_d;
   logic [W*NE-1:0]        shadow_q, shadow_d, out_q, out_d;

   logic signed [W-1:0]    l_ik, l_jk, d_kk;
   logic signed [AW-1:0]   term, sum;
   logic                   k_last, j_last, i_last;

   // Operand fetch with the unit-lower-triangular interpretation of L.
   always_comb begin
      l_ik = l_q[W*(int'(i_q)*N + int'(k_q)) +: W];
      l_jk = l_q[W*(int'(j_q)*N + int'(k_q)) +: W];
      d_kk = d_q[W*(int'(k_q)*N + int'(k_q)) +: W];
      if (k_q > i_q) begin
         l_ik = '0;
      end else if (k_q == i_q) begin
         l_ik = W'(1);
      end
      if (k_q > j_q) begin
         l_jk = '0;
      end else if (k_q == j_q) begin
         l_jk = W'(1);
      end
      term = AW'(l_ik) * AW'(d_kk) * AW'(l_jk);
      sum  = acc_q + term;
   end

   assign k_last = (k_q == CW'(N - 1));
   assign j_last = (j_q == CW'(N - 1));
   assign i_last = (i_q == CW'(N - 1));

   always_comb begin
      state_d  = state_q;
      i_d      = i_q;
      j_d      = j_q;
      k_d      = k_q;
      acc_d    = acc_q;
      l_d      = l_q;
      d_d      = d_q;
      shadow_d = shadow_q;
      out_d    = out_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               l_d     = L_in;
               d_d     = D_in;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               acc_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (k_last) begin
               // Element complete: keep the low W bits (wrap, no saturation).
               shadow_d[W*(int'(i_q)*N + int'(j_q)) +: W] = sum[W-1:0];
               acc_d = '0;
               k_d   = '0;
               if (j_last) begin
                  j_d = '0;
                  i_d = i_last ? '0 : i_q + CW'(1);
               end else begin
                  j_d = j_q + CW'(1);
               end
               if (j_last && i_last) begin
                  // Publish the whole matrix at once, including the element just finished.
                  out_d   = shadow_d;
                  state_d = StFin;
               end
            end else begin
               acc_d = sum;
               k_d   = k_q + CW'(1);
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= StIdle;
         i_q      <= '0;
         j_q      <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         l_q      <= '0;
         d_q      <= '0;
         shadow_q <= '0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         j_q      <= j_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         l_q      <= l_d;
         d_q      <= d_d;
         shadow_q <= shadow_d;
         out_q    <= out_d;
      end
   end

   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StFin);
   assign matrix_out = out_q;

endmodule
